// File: rtl/wb_stage_pkg.sv
// Shared constants and types for the writeback stage: CSR numbers, exception codes,
// rdcnt encodings and the registered MEM->WB payload.
package wb_stage_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;

  localparam logic [5:0]  ECODE_INT  = 6'h00;
  localparam logic [5:0]  ECODE_ADE  = 6'h08;
  localparam logic [5:0]  ECODE_ALE  = 6'h09;
  localparam logic [5:0]  ECODE_SYS  = 6'h0b;
  localparam logic [5:0]  ECODE_BRK  = 6'h0c;
  localparam logic [5:0]  ECODE_INE  = 6'h0d;

  localparam logic [8:0]  ESUBCODE_ADEF = 9'd0;
  localparam logic [8:0]  ESUBCODE_ADEM = 9'd1;

  localparam logic [1:0]  RDCNT_NONE = 2'b00;
  localparam logic [1:0]  RDCNT_VL   = 2'b01;
  localparam logic [1:0]  RDCNT_VH   = 2'b10;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic        gr_we;
    logic [4:0]  dest;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    logic [31:0] vaddr;
    logic        ertn;
  } ws_payload_t;

  function automatic logic [31:0] rdcnt_sel(input logic [1:0]  op,
                                            input logic [63:0] cnt,
                                            input logic [31:0] result);
    logic [31:0] sel;
    case (op)
      RDCNT_VL:   sel = cnt[31:0];
      RDCNT_VH:   sel = cnt[63:32];
      RDCNT_NONE: sel = result;
      default:    sel = result;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/wb_stage_stable_counter.sv
// stable_counter: free-running 64-bit timer read by rdcntvl.w / rdcntvh.w.
// Cleared by synchronous reset, +1 every cycle, wraps naturally at 2^64.
module stable_counter (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] cnt
);

  logic [63:0] cnt_q;
  logic [63:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 64'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/wb_stage.sv
// wb_stage: WB/commit stage; sole driver of CSR-file controls, flush, bypass and trace. Option: WB_STABLE_CNT_EN.
// Latency: commits one cycle after acceptance; backpressure: none, ws_allowin is always 1.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ms_to_ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic [31:0] ms_result,
  input  logic        ms_gr_we,
  input  logic [4:0]  ms_dest,
  input  logic        ms_csr_we,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_csr_wmask,
  input  logic [31:0] ms_csr_wvalue,
  input  logic        ms_ex,
  input  logic [5:0]  ms_ecode,
  input  logic [8:0]  ms_esubcode,
  input  logic [31:0] ms_vaddr,
  input  logic        ms_ertn,
  input  logic [1:0]  ms_rdcnt_op,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_vaddr,
  output logic        ertn_flush,
  output logic        wb_flush,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        ws_fwd_valid,
  output logic [4:0]  ws_fwd_dest,
  output logic [31:0] ws_fwd_data,
  output logic        ws_csr_busy,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  logic        ws_ready_go;
  logic        ws_valid_q;
  logic        ws_valid_d;
  logic        ws_load;
  ws_payload_t pl_q;
  ws_payload_t pl_d;

  assign ws_ready_go = 1'b1;
  assign ws_allowin  = ~ws_valid_q | ws_ready_go;
  assign ws_load     = ms_to_ws_valid & ws_allowin;

  always_comb begin
    ws_valid_d = ws_valid_q;
    pl_d       = pl_q;
    // A flushing commit also kills whatever MEM hands over in the same cycle.
    if (wb_flush) begin
      ws_valid_d = 1'b0;
    end else if (ws_allowin) begin
      ws_valid_d = ms_to_ws_valid;
    end
    if (ws_load) begin
      pl_d.pc         = ms_pc;
      pl_d.result     = ms_result;
      pl_d.gr_we      = ms_gr_we;
      pl_d.dest       = ms_dest;
      pl_d.csr_we     = ms_csr_we;
      pl_d.csr_num    = ms_csr_num;
      pl_d.csr_wmask  = ms_csr_wmask;
      pl_d.csr_wvalue = ms_csr_wvalue;
      pl_d.ex         = ms_ex;
      pl_d.ecode      = ms_ecode;
      pl_d.esubcode   = ms_esubcode;
      pl_d.vaddr      = ms_vaddr;
      pl_d.ertn       = ms_ertn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q <= 1'b0;
      pl_q       <= '0;
    end else begin
      ws_valid_q <= ws_valid_d;
      pl_q       <= pl_d;
    end
  end

`ifdef WB_STABLE_CNT_EN
  logic [63:0] cnt;
  logic [1:0]  rdcnt_q;
  logic [1:0]  rdcnt_d;

  stable_counter u_stable_counter (
    .clk   (clk),
    .reset (reset),
    .cnt   (cnt)
  );

  always_comb begin
    rdcnt_d = rdcnt_q;
    if (ws_load) begin
      rdcnt_d = ms_rdcnt_op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdcnt_q <= RDCNT_NONE;
    end else begin
      rdcnt_q <= rdcnt_d;
    end
  end

  assign rf_wdata = rdcnt_sel(rdcnt_q, cnt, pl_q.result);
`else
  logic unused_rdcnt_op;
  assign unused_rdcnt_op = ^ms_rdcnt_op;
  assign rf_wdata        = pl_q.result;
`endif

  // An excepting instruction must not retire any architectural side effect.
  assign wb_ex       = ws_valid_q & pl_q.ex;
  assign ertn_flush  = ws_valid_q & pl_q.ertn & ~pl_q.ex;
  assign wb_flush    = wb_ex | ertn_flush;

  assign csr_we      = ws_valid_q & pl_q.csr_we & ~pl_q.ex;
  assign csr_num     = pl_q.csr_num;
  assign csr_wmask   = pl_q.csr_wmask;
  assign csr_wvalue  = pl_q.csr_wvalue;

  assign wb_ecode    = pl_q.ecode;
  assign wb_esubcode = pl_q.esubcode;
  assign wb_pc       = pl_q.pc;
  assign wb_vaddr    = pl_q.vaddr;

  assign rf_we       = ws_valid_q & pl_q.gr_we & ~pl_q.ex;
  assign rf_waddr    = pl_q.dest;

  assign ws_fwd_valid = rf_we;
  assign ws_fwd_dest  = pl_q.dest;
  assign ws_fwd_data  = rf_wdata;
  assign ws_csr_busy  = ws_valid_q & (pl_q.csr_we | pl_q.ertn | pl_q.ex);

  assign debug_wb_pc       = pl_q.pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = pl_q.dest;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Directed table-driven bench for wb_stage plus hand sequences for flush-drop, reset
// mid-commit and (when WB_STABLE_CNT_EN is defined) the stable counter.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc, ms_result, ms_csr_wmask, ms_csr_wvalue, ms_vaddr;
  logic        ms_gr_we, ms_csr_we, ms_ex, ms_ertn;
  logic [4:0]  ms_dest;
  logic [13:0] ms_csr_num;
  logic [5:0]  ms_ecode;
  logic [8:0]  ms_esubcode;
  logic [1:0]  ms_rdcnt_op;
  logic        csr_we, wb_ex, ertn_flush, wb_flush, rf_we, ws_fwd_valid, ws_csr_busy;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask, csr_wvalue, wb_pc, wb_vaddr, rf_wdata, ws_fwd_data;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [4:0]  rf_waddr, ws_fwd_dest, debug_wb_rf_wnum;
  logic [3:0]  debug_wb_rf_we;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_result(ms_result), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
    .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num), .ms_csr_wmask(ms_csr_wmask),
    .ms_csr_wvalue(ms_csr_wvalue), .ms_ex(ms_ex), .ms_ecode(ms_ecode),
    .ms_esubcode(ms_esubcode), .ms_vaddr(ms_vaddr), .ms_ertn(ms_ertn),
    .ms_rdcnt_op(ms_rdcnt_op), .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask),
    .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush), .wb_flush(wb_flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .ws_fwd_valid(ws_fwd_valid),
    .ws_fwd_dest(ws_fwd_dest), .ws_fwd_data(ws_fwd_data), .ws_csr_busy(ws_csr_busy),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  typedef struct {
    logic        vld;
    logic [31:0] pc;
    logic [31:0] result;
    logic        gr_we;
    logic [4:0]  dest;
    logic        csr_we;
    logic [13:0] num;
    logic [31:0] wmask;
    logic [31:0] wvalue;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] vaddr;
    logic        ertn;
    logic        e_rf_we;
    logic        e_csr_we;
    logic        e_ex;
    logic        e_ertn;
    logic        e_flush;
    logic        e_busy;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ms_to_ws_valid = 1'b0; ms_pc = '0; ms_result = '0; ms_gr_we = 1'b0; ms_dest = '0;
    ms_csr_we = 1'b0; ms_csr_num = '0; ms_csr_wmask = '0; ms_csr_wvalue = '0;
    ms_ex = 1'b0; ms_ecode = '0; ms_esubcode = '0; ms_vaddr = '0; ms_ertn = 1'b0;
    ms_rdcnt_op = RDCNT_NONE;
  endtask

  task automatic drive_vec(input vec_t v);
    ms_to_ws_valid = v.vld; ms_pc = v.pc; ms_result = v.result; ms_gr_we = v.gr_we;
    ms_dest = v.dest; ms_csr_we = v.csr_we; ms_csr_num = v.num; ms_csr_wmask = v.wmask;
    ms_csr_wvalue = v.wvalue; ms_ex = v.ex; ms_ecode = v.ecode; ms_esubcode = v.esub;
    ms_vaddr = v.vaddr; ms_ertn = v.ertn; ms_rdcnt_op = RDCNT_NONE;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".rf_we"}, rf_we, 0);
    chk({tag, ".csr_we"}, csr_we, 0);
    chk({tag, ".wb_ex"}, wb_ex, 0);
    chk({tag, ".wb_flush"}, wb_flush, 0);
  endtask

`ifdef WB_STABLE_CNT_EN
  logic [63:0] tb_cnt;
  always @(posedge clk) begin
    if (reset) tb_cnt <= 64'd0;
    else       tb_cnt <= tb_cnt + 64'd1;
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    string t;
    idle_inputs();
    reset = 1'b1;

    //           vld pc          result        gr dst csr num     wmask         wvalue       ex ecode      esub           vaddr         ertn rf cs ex er fl bz
    vecs[0] = '{1'b1, 32'h1000, 32'h0000_1234, 1'b1, 5'd5,  1'b0, 14'h0,  32'h0,        32'h0,       1'b0, 6'h0,      9'd0,          32'h0,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h1004, 32'h0000_0077, 1'b1, 5'd3,  1'b1, 14'h30, 32'hFFFF_FFFF, 32'hA5A5,   1'b0, 6'h0,      9'd0,          32'h0,       1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 32'h1008, 32'h0000_0000, 1'b1, 5'd4,  1'b0, 14'h0,  32'h0,        32'h0,       1'b1, ECODE_ALE, 9'd0,          32'h1003,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 32'h100C, 32'h0000_0000, 1'b0, 5'd0,  1'b0, 14'h0,  32'h0,        32'h0,       1'b0, 6'h0,      9'd0,          32'h0,       1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 32'h1010, 32'h0000_0000, 1'b0, 5'd0,  1'b0, 14'h0,  32'h0,        32'h0,       1'b1, ECODE_INE, 9'd0,          32'h0,       1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 32'h1014, 32'h0000_0055, 1'b1, 5'd9,  1'b1, 14'h6,  32'h0000_00FF, 32'h1,      1'b1, ECODE_ADE, ESUBCODE_ADEM, 32'h2001,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 32'h1018, 32'hFFFF_FFFF, 1'b1, 5'd31, 1'b0, 14'h0,  32'h0,        32'h0,       1'b0, 6'h0,      9'd0,          32'h0,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 32'h9999, 32'hDEAD_BEEF, 1'b1, 5'd7,  1'b1, 14'h1,  32'h1,        32'h1,       1'b1, 6'h3F,     9'd3,          32'h5,       1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.allowin", ws_allowin, 1);
    chk_quiet("rst");
    chk("rst.ertn_flush", ertn_flush, 0);
    chk("rst.csr_busy", ws_csr_busy, 0);
    chk("rst.fwd_valid", ws_fwd_valid, 0);
    chk("rst.debug_we", debug_wb_rf_we, 0);
    chk("rst.debug_pc", debug_wb_pc, 0);
    chk("rst.csr_num", csr_num, 0);
    reset = 1'b0;

    // Table: accept at one edge, inspect the commit cycle, then one idle edge.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      @(posedge clk);
      #1 ms_to_ws_valid = 1'b0;
      @(negedge clk);
      t = $sformatf("vec%0d", i);
      chk({t, ".rf_we"}, rf_we, vecs[i].e_rf_we);
      chk({t, ".csr_we"}, csr_we, vecs[i].e_csr_we);
      chk({t, ".wb_ex"}, wb_ex, vecs[i].e_ex);
      chk({t, ".ertn_flush"}, ertn_flush, vecs[i].e_ertn);
      chk({t, ".wb_flush"}, wb_flush, vecs[i].e_flush);
      chk({t, ".csr_busy"}, ws_csr_busy, vecs[i].e_busy);
      chk({t, ".fwd_valid"}, ws_fwd_valid, vecs[i].e_rf_we);
      chk({t, ".debug_we"}, debug_wb_rf_we, {4{vecs[i].e_rf_we}});
      chk({t, ".allowin"}, ws_allowin, 1);
      if (vecs[i].e_rf_we) begin
        chk({t, ".rf_waddr"}, rf_waddr, vecs[i].dest);
        chk({t, ".rf_wdata"}, rf_wdata, vecs[i].result);
        chk({t, ".fwd_dest"}, ws_fwd_dest, vecs[i].dest);
        chk({t, ".fwd_data"}, ws_fwd_data, vecs[i].result);
        chk({t, ".debug_wnum"}, debug_wb_rf_wnum, vecs[i].dest);
        chk({t, ".debug_wdata"}, debug_wb_rf_wdata, vecs[i].result);
      end
      if (vecs[i].e_csr_we) begin
        chk({t, ".csr_num"}, csr_num, vecs[i].num);
        chk({t, ".csr_wmask"}, csr_wmask, vecs[i].wmask);
        chk({t, ".csr_wvalue"}, csr_wvalue, vecs[i].wvalue);
      end
      if (vecs[i].e_ex) begin
        chk({t, ".wb_ecode"}, wb_ecode, vecs[i].ecode);
        chk({t, ".wb_esub"}, wb_esubcode, vecs[i].esub);
        chk({t, ".wb_vaddr"}, wb_vaddr, vecs[i].vaddr);
        chk({t, ".wb_pc"}, wb_pc, vecs[i].pc);
      end
      if (vecs[i].vld) chk({t, ".debug_pc"}, debug_wb_pc, vecs[i].pc);
    end

    // Flush drops the instruction arriving in the commit cycle; wb_ex lasts one cycle.
    @(negedge clk);
    drive_vec(vecs[2]);
    @(posedge clk);
    #1 drive_vec(vecs[0]);
    ms_dest = 5'd7;
    @(negedge clk);
    chk("drop.flush", wb_flush, 1);
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    chk_quiet("drop.next");
    chk("drop.fwd_valid", ws_fwd_valid, 0);
    chk("drop.busy", ws_csr_busy, 0);

    // Back-to-back plain commits with no bubble.
    @(negedge clk);
    drive_vec(vecs[0]);
    @(posedge clk);
    #1 drive_vec(vecs[6]);
    @(negedge clk);
    chk("b2b.first_waddr", rf_waddr, 5);
    chk("b2b.first_wdata", rf_wdata, 32'h1234);
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    chk("b2b.second_we", rf_we, 1);
    chk("b2b.second_waddr", rf_waddr, 31);
    chk("b2b.second_wdata", rf_wdata, 32'hFFFF_FFFF);

    // Reset asserted while a CSR write is committing.
    @(negedge clk);
    drive_vec(vecs[1]);
    @(posedge clk);
    #1 drive_vec(vecs[2]);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid.before_csr_we", csr_we, 1);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk_quiet("rstmid");
    end
    idle_inputs();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_quiet("rstmid.release");

`ifdef WB_STABLE_CNT_EN
    // Counter: release reset, 10 edges, then rdcntvl.w and rdcntvh.w.
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    drive_vec(vecs[0]);
    ms_dest = 5'd6;
    ms_rdcnt_op = RDCNT_VL;
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    chk("cnt.vl_model", rf_wdata, tb_cnt[31:0]);
    chk("cnt.vl_value", rf_wdata, 32'd11);
    @(negedge clk);
    drive_vec(vecs[0]);
    ms_rdcnt_op = RDCNT_VH;
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    chk("cnt.vh_model", rf_wdata, tb_cnt[63:32]);
    chk("cnt.vh_zero", rf_wdata, 0);
    force dut.u_stable_counter.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.u_stable_counter.cnt_q;
    @(posedge clk);
    #1 chk("cnt.wrap", dut.u_stable_counter.cnt, 64'd0);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
